// File: rtl/posit_dot_accumulator.sv
// ============================================================================
// Module  : posit_dot_accumulator
// Brief   : Exact posit dot product; decoded operand pairs accumulate into a quire
// Rev     : 1.0
// ============================================================================
`default_nettype none

module posit_dot_accumulator #(
  parameter  int WIDTH = 8,
  parameter  int EXP   = 2,
  parameter  int GUARD = 8,
  localparam int REGI  = $clog2(WIDTH) + 1,
  localparam int MTS   = WIDTH - 3 - EXP,
  localparam int MAXS  = (2 ** EXP) * (WIDTH - 1) - 1,
  localparam int QW    = 4 * MAXS + 2 * MTS + GUARD + 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            decode,
  input  logic            last_i,
  input  logic            clear_i,
  input  logic            sign_s,
  input  logic            sign_l,
  input  logic [REGI-1:0] regi_s,
  input  logic [REGI-1:0] regi_l,
  input  logic [EXP-1:0]  exp_s,
  input  logic [EXP-1:0]  exp_l,
  input  logic [MTS-1:0]  mts_s,
  input  logic [MTS-1:0]  mts_l,
  input  logic [1:0]      vld_o_w,
  input  logic [1:0]      vld_o_d,
  output logic [QW-1:0]   acc_o,
  output logic            nar_o,
  output logic            ovf_o,
  output logic            out_vld_o,
  output logic            busy_o
);

  localparam int SCW = REGI + EXP;
  localparam int SSW = 2 * REGI + EXP + 1;
  localparam int PW  = 2 * MTS + 2;

  localparam logic [SSW-1:0] c_bias     = SSW'(2 * MAXS);
  localparam logic [1:0]     c_cls_zero = 2'b00;
  localparam logic [1:0]     c_cls_norm = 2'b01;
  localparam logic [1:0]     c_cls_nar  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_NAR  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_s1_vld;
  logic            r_s1_last;
  logic            r_s1_sign;
  logic [1:0]      r_s1_cls;
  logic [SSW-1:0]  r_s1_ssum;
  logic [PW-1:0]   r_s1_prod;
  logic [QW-1:0]   r_quire;
  logic            r_ovf;

  logic [SCW-1:0]  w_scale_s;
  logic [SCW-1:0]  w_scale_l;
  logic [SSW-1:0]  w_ssum;
  logic [PW-1:0]   w_prod;
  logic [1:0]      w_cls;
  logic [SSW-1:0]  w_shamt;
  logic [QW-1:0]   w_mag;
  logic [QW-1:0]   w_term;
  logic [QW-1:0]   w_base;
  logic [QW-1:0]   w_sum;
  logic            w_add_ovf;
  logic            w_term_nar;
  logic            w_nar_any;

  // k*2^EXP + e is just the regime bits concatenated above the exponent bits
  assign w_scale_s = {regi_s, exp_s};
  assign w_scale_l = {regi_l, exp_l};
  assign w_ssum    = {{(SSW-SCW){w_scale_s[SCW-1]}}, w_scale_s}
                   + {{(SSW-SCW){w_scale_l[SCW-1]}}, w_scale_l};
  assign w_prod    = PW'({1'b1, mts_s}) * PW'({1'b1, mts_l});

  always_comb begin
    w_cls = c_cls_norm;
    if (vld_o_w == c_cls_nar || vld_o_d == c_cls_nar) begin
      w_cls = c_cls_nar;
    end else if (vld_o_w == c_cls_zero || vld_o_d == c_cls_zero) begin
      w_cls = c_cls_zero;
    end
  end

  // Biased scale is non-negative for legal operands and indexes the quire directly
  assign w_shamt = r_s1_ssum + c_bias;
  assign w_mag   = QW'(r_s1_prod) << w_shamt;

  always_comb begin
    w_term = '0;
    if (r_s1_cls != c_cls_zero) begin
      w_term = r_s1_sign ? (~w_mag + QW'(1)) : w_mag;
    end
  end

  assign w_base     = (r_state == S_IDLE) ? '0 : r_quire;
  assign w_sum      = w_base + w_term;
  assign w_add_ovf  = (w_base[QW-1] == w_term[QW-1]) && (w_sum[QW-1] != w_base[QW-1]);
  assign w_term_nar = (r_s1_cls == c_cls_nar);
  assign w_nar_any  = w_term_nar || (r_state == S_NAR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_cls  <= c_cls_zero;
      r_s1_ssum <= '0;
      r_s1_prod <= '0;
      r_quire   <= '0;
      r_ovf     <= 1'b0;
      acc_o     <= '0;
      nar_o     <= 1'b0;
      ovf_o     <= 1'b0;
      out_vld_o <= 1'b0;
      busy_o    <= 1'b0;
    end else if (clear_i) begin
      r_state   <= S_IDLE;
      r_s1_vld  <= 1'b0;
      r_quire   <= '0;
      r_ovf     <= 1'b0;
      out_vld_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      r_s1_vld  <= decode;
      out_vld_o <= 1'b0;
      if (decode) begin
        r_s1_last <= last_i;
        r_s1_sign <= sign_s ^ sign_l;
        r_s1_cls  <= w_cls;
        r_s1_ssum <= w_ssum;
        r_s1_prod <= w_prod;
      end

      if (r_s1_vld) begin
        if (r_s1_last) begin
          r_state   <= S_IDLE;
          r_quire   <= '0;
          r_ovf     <= 1'b0;
          busy_o    <= 1'b0;
          out_vld_o <= 1'b1;
          nar_o     <= w_nar_any;
          acc_o     <= w_nar_any ? '0 : w_sum;
          ovf_o     <= w_nar_any ? 1'b0 : (r_ovf | w_add_ovf);
        end else if (w_nar_any) begin
          r_state <= S_NAR;
          busy_o  <= 1'b1;
        end else begin
          r_state <= S_ACC;
          r_quire <= w_sum;
          r_ovf   <= r_ovf | w_add_ovf;
          busy_o  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_posit_dot_accumulator.sv
// ============================================================================
// Module  : tb_posit_dot_accumulator
// Brief   : Scoreboard bench for posit_dot_accumulator
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_posit_dot_accumulator;

  localparam int WIDTH = 8;
  localparam int EXP   = 2;
  localparam int GUARD = 8;
  localparam int REGI  = 4;
  localparam int MTS   = 3;
  localparam int QW    = 125;

  localparam logic [1:0] ZER = 2'b00;
  localparam logic [1:0] NRM = 2'b01;
  localparam logic [1:0] NAR = 2'b10;

  logic            clk_i   = 1'b0;
  logic            rst_i   = 1'b0;
  logic            decode  = 1'b0;
  logic            last_i  = 1'b0;
  logic            clear_i = 1'b0;
  logic            sign_s  = 1'b0;
  logic            sign_l  = 1'b0;
  logic [REGI-1:0] regi_s  = '0;
  logic [REGI-1:0] regi_l  = '0;
  logic [EXP-1:0]  exp_s   = '0;
  logic [EXP-1:0]  exp_l   = '0;
  logic [MTS-1:0]  mts_s   = '0;
  logic [MTS-1:0]  mts_l   = '0;
  logic [1:0]      vld_o_w = NRM;
  logic [1:0]      vld_o_d = NRM;
  logic [QW-1:0]   acc_o;
  logic            nar_o;
  logic            ovf_o;
  logic            out_vld_o;
  logic            busy_o;

  typedef struct {
    logic [QW-1:0] acc;
    logic          nar;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  posit_dot_accumulator #(
    .WIDTH (WIDTH),
    .EXP   (EXP),
    .GUARD (GUARD)
  ) u_dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .decode    (decode),
    .last_i    (last_i),
    .clear_i   (clear_i),
    .sign_s    (sign_s),
    .sign_l    (sign_l),
    .regi_s    (regi_s),
    .regi_l    (regi_l),
    .exp_s     (exp_s),
    .exp_l     (exp_l),
    .mts_s     (mts_s),
    .mts_l     (mts_l),
    .vld_o_w   (vld_o_w),
    .vld_o_d   (vld_o_d),
    .acc_o     (acc_o),
    .nar_o     (nar_o),
    .ovf_o     (ovf_o),
    .out_vld_o (out_vld_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [QW-1:0] pw(input int n);
    logic [QW-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic put(input logic ss, input int ks, input int es, input int ms, input logic [1:0] cs,
                     input logic sl, input int kl, input int el, input int ml, input logic [1:0] cl,
                     input logic lst, input logic [QW-1:0] eacc = '0,
                     input logic enar = 1'b0, input logic eovf = 1'b0);
    sign_s  = ss;  regi_s = ks[REGI-1:0]; exp_s = es[EXP-1:0]; mts_s = ms[MTS-1:0]; vld_o_w = cs;
    sign_l  = sl;  regi_l = kl[REGI-1:0]; exp_l = el[EXP-1:0]; mts_l = ml[MTS-1:0]; vld_o_d = cl;
    decode  = 1'b1;
    last_i  = lst;
    @(posedge clk_i);
    #1;
    if (lst) sb.push_back('{eacc, enar, eovf, cyc + 1});
    decode = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic one11(input logic lst, input logic [QW-1:0] eacc = '0);
    put(1'b0, 0, 0, 0, NRM, 1'b0, 0, 0, 0, NRM, lst, eacc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_acc"},  128'(acc_o),     128'(0));
    chk({tag, "_nar"},  128'(nar_o),     128'(0));
    chk({tag, "_ovf"},  128'(ovf_o),     128'(0));
    chk({tag, "_vld"},  128'(out_vld_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy_o),    128'(0));
  endtask

  always @(negedge clk_i) begin
    if (out_vld_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_vld", 128'(out_vld_o), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_acc", 128'(acc_o), 128'(e.acc));
        chk("res_nar", 128'(nar_o), 128'(e.nar));
        chk("res_ovf", 128'(ovf_o), 128'(e.ovf));
        chk("res_latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_i = 1'b1;
    idle(2);
    chk_zero_outputs("reset");
    rst_i = 1'b0;
    idle(1);

    // single term 1x1
    one11(1'b1, pw(60));
    idle(3);

    // 1.5x2 then 1.0x(-1.0)
    put(1'b0, 0, 0, 4, NRM, 1'b0, 0, 1, 0, NRM, 1'b0);
    put(1'b0, 0, 0, 0, NRM, 1'b1, 0, 0, 0, NRM, 1'b1, pw(61));
    idle(3);

    // back-to-back sums
    one11(1'b1, pw(60));
    one11(1'b0);
    one11(1'b1, pw(61));
    idle(3);

    // NaR mid-sum, then NaR on a single last term
    one11(1'b0);
    put(1'b0, 0, 0, 0, NAR, 1'b0, 0, 0, 0, NRM, 1'b0);
    chk("busy_mid", 128'(busy_o), 128'(1));
    one11(1'b1, '0);
    sb[sb.size()-1].nar = 1'b1;
    idle(3);
    chk("busy_idle", 128'(busy_o), 128'(0));
    put(1'b0, 0, 0, 0, NRM, 1'b0, 0, 0, 0, NAR, 1'b1, '0, 1'b1, 1'b0);
    idle(3);

    // zero-class operand with nonzero fields contributes nothing
    put(1'b1, 3, 2, 7, ZER, 1'b0, 0, 0, 0, NRM, 1'b0);
    one11(1'b1, pw(60));
    idle(3);

    // extremes maxpos^2 + minpos^2
    put(1'b0, 6, 0, 0, NRM, 1'b0, 6, 0, 0, NRM, 1'b0);
    put(1'b0, -6, 0, 0, NRM, 1'b0, -6, 0, 0, NRM, 1'b1, pw(108) | pw(12));
    idle(3);

    // 300 largest in-range terms wrap the quire: 300*225 << 108
    for (int i = 0; i < 300; i++) begin
      put(1'b0, 6, 3, 7, NRM, 1'b0, 6, 3, 7, NRM, (i == 299), QW'(67500) << 108, 1'b0, 1'b1);
    end
    idle(3);
    one11(1'b1, pw(60));
    idle(3);

    // asynchronous reset between 2nd and 3rd of 4 terms
    one11(1'b0);
    one11(1'b0);
    chk("busy_pre_rst", 128'(busy_o), 128'(1));
    rst_i = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    one11(1'b0);
    one11(1'b1, pw(61));
    idle(3);
    one11(1'b1, pw(60));
    idle(3);

    // clear mid-sum with a simultaneous last term that must be dropped
    one11(1'b0);
    one11(1'b0);
    decode  = 1'b1;
    last_i  = 1'b1;
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    decode  = 1'b0;
    last_i  = 1'b0;
    clear_i = 1'b0;
    chk("busy_post_clear", 128'(busy_o), 128'(0));
    one11(1'b1, pw(60));
    idle(4);
    chk("busy_end", 128'(busy_o), 128'(0));

    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
